// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master (mode 0, MSB first) behind a simple handshake bus.
//
// Ports
//    clk_i, rst_i             system clock, synchronous active-high reset
//    hs_rd_i, hs_wr_i         bus read / write request (write wins if both high)
//    hs_addr_i[31:0]          byte address, bits [7:0] decoded
//    hs_data_i[31:0]          write data
//    hs_ready_o               one-cycle completion pulse, cycle after accept
//    hs_data_o[31:0]          read data, valid while hs_ready_o=1
//    spi_sck_o, spi_cs_no     serial clock, active-low chip select
//    spi_mosi_o, spi_miso_i   serial data out / in
//
// Register map: 0x00/0x60 CTRL, 0x04 STATUS, 0x08 TXDATA, 0x0C RXDATA,
//               0x10 TXOCC, 0x14 RXOCC.
//
// Byte-wide FIFO used for both TX and RX.
// Ports: i_clr empties the FIFO; a push in the same cycle lands after the clear.
//        o_data is the current head (valid when o_empty=0).

module spi_master_ctrl_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [7:0]                 i_data,
   output logic [7:0]                 o_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;
   logic [AW-1:0] w_waddr;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   // A clear frees all space, so a push in the clear cycle is never dropped.
   assign w_do_push = i_push & (i_clr | ~o_full);
   assign w_do_pop  = i_pop & ~o_empty & ~i_clr;
   assign w_waddr   = i_clr ? '0 : r_wptr;

   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[w_waddr] <= i_data;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clr) begin
         r_rptr  <= '0;
         r_wptr  <= w_do_push ? AW'(1) : '0;
         r_count <= w_do_push ? CW'(1) : '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// Shift engine states
//    state   | meaning
//    S_IDLE  | CS high, waiting for TX data with inhibit clear
//    S_SETUP | CS low, first bit on MOSI before the first SCK rise
//    S_HIGH  | SCK high; MISO sampled on entry
//    S_LOW   | SCK low; next bit presented on MOSI
//    S_NEXT  | byte boundary: push RX byte, chain next TX byte or release CS

module spi_master_ctrl #(
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hs_rd_i,
   input  logic        hs_wr_i,
   input  logic [31:0] hs_addr_i,
   input  logic [31:0] hs_data_i,
   output logic        hs_ready_o,
   output logic [31:0] hs_data_o,
   output logic        spi_sck_o,
   output logic        spi_cs_no,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_NEXT} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_shift;
   logic [7:0]    r_rx;
   logic [3:0]    r_bits;
   logic          r_ready;
   logic [31:0]   r_rdata;
   logic          r_inhibit;
   logic          r_overrun;

   logic          w_accept, w_wr, w_rd;
   logic [7:0]    w_addr;
   logic          w_sel_ctrl, w_sel_stat, w_sel_txd, w_sel_rxd, w_sel_txocc, w_sel_rxocc;
   logic          w_tx_clr, w_rx_clr, w_tx_push_bus, w_rx_pop_bus, w_stat_rd, w_ov_set;
   logic [31:0]   w_rdata;
   logic          w_tc, w_start, w_busy, w_tx_pop_eng, w_rx_push_eng;
   logic          w_enter_high, w_shift_out;
   logic [7:0]    w_tx_dout, w_rx_dout;
   logic [CW-1:0] w_tx_count, w_rx_count;
   logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic          w_unused;

   assign w_unused = ^{hs_addr_i[31:8], hs_data_i[31:8]};

   // ---------------- bus side ----------------
   assign w_accept      = (hs_rd_i | hs_wr_i) & ~r_ready;
   assign w_wr          = w_accept & hs_wr_i;
   assign w_rd          = w_accept & ~hs_wr_i;
   assign w_addr        = hs_addr_i[7:0];
   assign w_sel_ctrl    = (w_addr == 8'h00) | (w_addr == 8'h60);
   assign w_sel_stat    = (w_addr == 8'h04);
   assign w_sel_txd     = (w_addr == 8'h08);
   assign w_sel_rxd     = (w_addr == 8'h0C);
   assign w_sel_txocc   = (w_addr == 8'h10);
   assign w_sel_rxocc   = (w_addr == 8'h14);
   assign w_tx_clr      = w_wr & w_sel_ctrl & hs_data_i[3];
   assign w_rx_clr      = w_wr & w_sel_ctrl & hs_data_i[4];
   assign w_tx_push_bus = w_wr & w_sel_txd;
   assign w_rx_pop_bus  = w_rd & w_sel_rxd;
   assign w_stat_rd     = w_rd & w_sel_stat;
   // A byte landing in the RX clear cycle is kept, so it cannot overrun.
   assign w_ov_set      = w_rx_push_eng & w_rx_full & ~w_rx_clr;

   always_comb begin
      w_rdata = '0;
      if (w_sel_ctrl)
         w_rdata = {29'd0, r_inhibit, 2'b00};
      else if (w_sel_stat)
         w_rdata = {26'd0, r_overrun, w_busy, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
      else if (w_sel_rxd)
         w_rdata = w_rx_empty ? 32'd0 : {24'd0, w_rx_dout};
      else if (w_sel_txocc)
         w_rdata = {{(32-CW){1'b0}}, w_tx_count};
      else if (w_sel_rxocc)
         w_rdata = {{(32-CW){1'b0}}, w_rx_count};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ready   <= 1'b0;
         r_rdata   <= '0;
         r_inhibit <= 1'b1;
         r_overrun <= 1'b0;
      end else begin
         r_ready <= w_accept;
         if (w_accept) r_rdata <= w_rd ? w_rdata : 32'd0;
         if (w_wr & w_sel_ctrl) r_inhibit <= hs_data_i[2];
         if (w_ov_set)       r_overrun <= 1'b1;
         else if (w_stat_rd) r_overrun <= 1'b0;
      end
   end

   assign hs_ready_o = r_ready;
   assign hs_data_o  = r_rdata;

   spi_master_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_clr   (w_tx_clr),
      .i_push  (w_tx_push_bus),
      .i_pop   (w_tx_pop_eng),
      .i_data  (hs_data_i[7:0]),
      .o_data  (w_tx_dout),
      .o_count (w_tx_count),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

   spi_master_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_clr   (w_rx_clr),
      .i_push  (w_rx_push_eng),
      .i_pop   (w_rx_pop_bus),
      .i_data  (r_rx),
      .o_data  (w_rx_dout),
      .o_count (w_rx_count),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty)
   );

   // ---------------- shift engine ----------------
   assign w_tc    = (r_timer == '0);
   assign w_start = ~r_inhibit & ~w_tx_empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_SETUP;
         S_SETUP: if (w_tc)    w_state_nxt = S_HIGH;
         S_HIGH:  if (w_tc)    w_state_nxt = (r_bits == 4'd8) ? S_NEXT : S_LOW;
         S_LOW:   if (w_tc)    w_state_nxt = S_HIGH;
         S_NEXT:  w_state_nxt = w_start ? S_LOW : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      spi_sck_o     = 1'b0;
      spi_cs_no     = 1'b1;
      spi_mosi_o    = 1'b0;
      w_busy        = 1'b0;
      w_tx_pop_eng  = 1'b0;
      w_rx_push_eng = 1'b0;
      case (r_state)
         S_IDLE: w_tx_pop_eng = w_start;
         S_HIGH: begin
            spi_sck_o  = 1'b1;
            spi_cs_no  = 1'b0;
            spi_mosi_o = r_shift[7];
            w_busy     = 1'b1;
         end
         S_NEXT: begin
            spi_cs_no     = 1'b0;
            spi_mosi_o    = r_shift[7];
            w_busy        = 1'b1;
            w_rx_push_eng = 1'b1;
            w_tx_pop_eng  = w_start;
         end
         default: begin
            spi_cs_no  = 1'b0;
            spi_mosi_o = r_shift[7];
            w_busy     = 1'b1;
         end
      endcase
   end

   assign w_enter_high = (w_state_nxt == S_HIGH) && (r_state != S_HIGH);
   assign w_shift_out  = (r_state == S_HIGH) && (w_state_nxt == S_LOW);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_timer <= '0;
         r_shift <= '0;
         r_rx    <= '0;
         r_bits  <= '0;
      end else begin
         // Every phase reloads the down-counter; terminal count ends the phase.
         if (w_state_nxt != r_state) r_timer <= DIV_LOAD;
         else if (!w_tc)             r_timer <= r_timer - TW'(1);

         if (w_tx_pop_eng) begin
            r_shift <= w_tx_dout;
            r_bits  <= '0;
         end else if (w_shift_out) begin
            r_shift <= {r_shift[6:0], 1'b0};
         end

         if (w_enter_high) begin
            r_rx   <= {r_rx[6:0], spi_miso_i};
            r_bits <= r_bits + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        hs_rd_i = 1'b0;
   logic        hs_wr_i = 1'b0;
   logic [31:0] hs_addr_i = '0;
   logic [31:0] hs_data_i = '0;
   logic        hs_ready_o;
   logic [31:0] hs_data_o;
   logic        spi_sck_o;
   logic        spi_cs_no;
   logic        spi_mosi_o;
   logic        spi_miso_i;

   int total = 0;
   int bad   = 0;

   int         sck_rise = 0;
   int         cs_rise  = 0;
   int         cs_fall  = 0;
   int         mosi_unstable = 0;
   logic [7:0] mosi_log = '0;
   logic       mosi_neg = 1'b0;

   spi_master_ctrl dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .hs_rd_i    (hs_rd_i),
      .hs_wr_i    (hs_wr_i),
      .hs_addr_i  (hs_addr_i),
      .hs_data_i  (hs_data_i),
      .hs_ready_o (hs_ready_o),
      .hs_data_o  (hs_data_o),
      .spi_sck_o  (spi_sck_o),
      .spi_cs_no  (spi_cs_no),
      .spi_mosi_o (spi_mosi_o),
      .spi_miso_i (spi_miso_i)
   );

   // MISO looped back to MOSI: every received byte equals the byte sent.
   assign spi_miso_i = spi_mosi_o;

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) mosi_neg = spi_mosi_o;
   always @(posedge spi_sck_o) begin
      sck_rise = sck_rise + 1;
      mosi_log = {mosi_log[6:0], spi_mosi_o};
      if (spi_mosi_o !== mosi_neg) mosi_unstable = mosi_unstable + 1;
   end
   always @(posedge spi_cs_no) cs_rise = cs_rise + 1;
   always @(negedge spi_cs_no) cs_fall = cs_fall + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      chk(tag, {31'd0, obs}, {31'd0, expv});
   endtask

   task automatic bus_xfer(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
      @(negedge clk_i);
      hs_wr_i   = wr;
      hs_rd_i   = rd;
      hs_addr_i = addr;
      hs_data_i = wdata;
      @(posedge clk_i);
      #1;
      hs_wr_i = 1'b0;
      hs_rd_i = 1'b0;
      chk1("ready_pulse", hs_ready_o, 1'b1);
      rdata = hs_data_o;
      @(posedge clk_i);
      #1;
      chk1("ready_single", hs_ready_o, 1'b0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] d;
      bus_xfer(1'b1, 1'b0, addr, data, d);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] expv);
      logic [31:0] d;
      bus_xfer(1'b0, 1'b1, addr, 32'd0, d);
      chk(tag, d, expv);
   endtask

   task automatic wait_cs_rise(input string tag, input int target);
      int n = 0;
      while (cs_rise < target && n < 3000) begin
         @(negedge clk_i);
         n++;
      end
      chk1(tag, cs_rise >= target, 1'b1);
   endtask

   initial begin
      logic [7:0]  vec8 [8];
      logic        sck_s [70];
      logic [31:0] d;
      int base_sck, base_rise, base_fall, base_unst;
      int hi_runs, bad_runs, run, n;
      logic prev, seen_hi;

      vec8 = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};

      // reset values
      repeat (3) @(posedge clk_i);
      #1;
      chk1("rst_ready", hs_ready_o, 1'b0);
      chk("rst_data", hs_data_o, 32'd0);
      chk1("rst_cs", spi_cs_no, 1'b1);
      chk1("rst_sck", spi_sck_o, 1'b0);
      chk1("rst_mosi", spi_mosi_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;

      rd_chk("status_after_rst", 32'h04, 32'h05);
      chk1("cs_idle", spi_cs_no, 1'b1);
      rd_chk("ctrl_after_rst", 32'h00, 32'h04);

      // eight bytes queued while inhibited, then released through the CTRL alias
      wr(32'h00, 32'h4);
      base_sck = sck_rise;
      for (int i = 0; i < 8; i++) wr(32'h08, {24'd0, vec8[i]});
      rd_chk("txocc_8", 32'h10, 32'd8);
      chk("sck_quiet_inhibit", 32'(sck_rise - base_sck), 32'd0);
      rd_chk("status_tx_pending", 32'h04, 32'h04);
      base_rise = cs_rise;
      base_fall = cs_fall;
      wr(32'h60, 32'h0);
      wait_cs_rise("burst_done", base_rise + 1);
      chk("burst_sck_pulses", 32'(sck_rise - base_sck), 32'd64);
      chk("burst_cs_single_low", 32'(cs_fall - base_fall), 32'd1);
      rd_chk("rxocc_8", 32'h14, 32'd8);
      for (int i = 0; i < 8; i++) rd_chk("rx_byte", 32'h0C, {24'd0, vec8[i]});
      rd_chk("status_drained", 32'h04, 32'h05);

      // held request: accepted, ignored during ready, accepted again
      @(negedge clk_i);
      hs_rd_i   = 1'b1;
      hs_addr_i = 32'h10;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i);
         #1;
         chk1("held_req_ready", hs_ready_o, (i % 2) == 0);
      end
      hs_rd_i = 1'b0;
      @(posedge clk_i);
      #1;

      // 0xA5 waveform: phase lengths, MOSI order and stability at SCK rise
      wr(32'h00, 32'h4);
      wr(32'h08, 32'hA5);
      base_unst = mosi_unstable;
      base_sck  = sck_rise;
      wr(32'h00, 32'h0);
      for (int i = 0; i < 70; i++) begin
         @(negedge clk_i);
         sck_s[i] = spi_sck_o;
      end
      hi_runs = 0; bad_runs = 0; run = 0; prev = 1'b0; seen_hi = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (sck_s[i] == prev) run++;
         else begin
            if (prev) begin
               hi_runs++;
               if (run != 2) bad_runs++;
            end else if (seen_hi) begin
               if (run != 2) bad_runs++;
            end
            if (sck_s[i]) seen_hi = 1'b1;
            prev = sck_s[i];
            run  = 1;
         end
      end
      chk("a5_high_phases", 32'(hi_runs), 32'd8);
      chk("a5_phase_len_errors", 32'(bad_runs), 32'd0);
      chk("a5_sck_pulses", 32'(sck_rise - base_sck), 32'd8);
      chk("a5_mosi_bits", {24'd0, mosi_log}, 32'hA5);
      chk("a5_mosi_unstable", 32'(mosi_unstable - base_unst), 32'd0);
      rd_chk("a5_rxocc", 32'h14, 32'd1);
      rd_chk("a5_rx_byte", 32'h0C, 32'hA5);

      // RX full, then overrun
      wr(32'h00, 32'h4);
      for (int i = 0; i < 16; i++) wr(32'h08, 32'(8'h10 + i));
      base_rise = cs_rise;
      wr(32'h00, 32'h0);
      wait_cs_rise("fill_done", base_rise + 1);
      rd_chk("rxocc_full", 32'h14, 32'd16);
      rd_chk("status_rx_full", 32'h04, 32'h09);
      base_rise = cs_rise;
      wr(32'h08, 32'h77);
      wait_cs_rise("ovr_byte_done", base_rise + 1);
      rd_chk("rxocc_after_ovr", 32'h14, 32'd16);
      rd_chk("status_overrun", 32'h04, 32'h29);
      rd_chk("status_ovr_cleared", 32'h04, 32'h09);
      rd_chk("rx_head_kept", 32'h0C, 32'h10);
      wr(32'h00, 32'h10);
      rd_chk("rxocc_after_clr", 32'h14, 32'd0);
      rd_chk("ctrl_selfclear", 32'h00, 32'd0);

      // TX overflow, empty pop, unmapped / read-only / write-only accesses
      wr(32'h00, 32'h4);
      for (int i = 0; i < 17; i++) wr(32'h08, 32'(i));
      rd_chk("txocc_full", 32'h10, 32'd16);
      rd_chk("status_tx_full", 32'h04, 32'h06);
      rd_chk("rx_empty_pop", 32'h0C, 32'd0);
      rd_chk("rxocc_still_0", 32'h14, 32'd0);
      rd_chk("unmapped_read", 32'h18, 32'd0);
      wr(32'h04, 32'hFFFF_FFFF);
      rd_chk("status_ro_write", 32'h04, 32'h06);
      rd_chk("txdata_read", 32'h08, 32'd0);
      wr(32'h00, 32'h0C);
      rd_chk("txocc_after_clr", 32'h10, 32'd0);
      rd_chk("ctrl_alias_read", 32'h60, 32'h04);
      bus_xfer(1'b1, 1'b1, 32'h08, 32'h5A, d);
      rd_chk("rdwr_is_write", 32'h10, 32'd1);

      // reset during the third bit
      wr(32'h08, 32'h3C);
      base_sck = sck_rise;
      wr(32'h00, 32'h0);
      n = 0;
      while (sck_rise < base_sck + 3 && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      chk1("reach_bit3", sck_rise >= base_sck + 3, 1'b1);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk1("abort_cs", spi_cs_no, 1'b1);
      chk1("abort_sck", spi_sck_o, 1'b0);
      chk1("abort_mosi", spi_mosi_o, 1'b0);
      chk1("abort_ready", hs_ready_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;
      rd_chk("abort_rxocc", 32'h14, 32'd0);
      rd_chk("abort_txocc", 32'h10, 32'd0);
      rd_chk("abort_ctrl", 32'h00, 32'h04);
      rd_chk("abort_status", 32'h04, 32'h05);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
